// File: rtl/instr_fetch_unit_if.sv
// Decoder-facing instruction handshake: {instr, pc} with valid/ready.
// master = fetch unit (producer), slave = decoder (consumer).
interface instr_fetch_unit_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  modport master (output instr_valid, output instr_out, output pc_out, input instr_ready);
  modport slave  (input instr_valid, input instr_out, input pc_out, output instr_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-outstanding fetch to a 1-cycle synchronous imem,
// DEPTH-entry {instr, pc} FIFO toward decode, redirect flush and misalignment halt.
//
// state   | meaning
// ST_RUN  | fetching, FIFO fed from imem responses
// ST_ERR  | halted after misaligned redirect; FIFO drains, no new fetches
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  instr_fetch_unit_if.master         dec,
  output logic                       misaligned_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ST_RUN, ST_ERR} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     mem_instr_q [DEPTH];
  logic [31:0]     mem_instr_d [DEPTH];
  logic [31:0]     mem_pc_q    [DEPTH];
  logic [31:0]     mem_pc_d    [DEPTH];

  logic            head_valid;
  logic            pop;
  logic            push;
  logic [CW:0]     occ;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mem_instr_d   = mem_instr_q;
    mem_pc_d      = mem_pc_q;

    // Outputs are masked while rst is high because reset is synchronous.
    head_valid      = !rst && (count_q != '0);
    dec.instr_valid = head_valid;
    dec.instr_out   = head_valid ? mem_instr_q[rd_ptr_q] : NOP_INSTR;
    dec.pc_out      = head_valid ? mem_pc_q[rd_ptr_q] : 32'h0;
    misaligned_err  = !rst && (state_q == ST_ERR);

    pop  = head_valid && dec.instr_ready;
    push = inflight_q;
    occ  = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);

    imem_req  = !rst && (state_q == ST_RUN) && !redirect_valid && (occ < (CW+1)'(DEPTH));
    imem_addr = pc_q;

    if (push) begin
      mem_instr_d[wr_ptr_q] = imem_rdata;
      mem_pc_d[wr_ptr_q]    = inflight_pc_q;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (imem_req) begin
      pc_d          = pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    // Redirect flushes everything, including the response landing this edge.
    if (redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = 1'b0;
      pc_d       = {redirect_pc[31:2], 2'b00};
      state_d    = (redirect_pc[1:0] != 2'b00) ? ST_ERR : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_instr_q <= mem_instr_d;
    mem_pc_q    <= mem_pc_d;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fill/latency, backpressure, redirect flush,
// misaligned halt and recovery, PC wrap, mid-stream reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        misaligned_err;
  int          n_vec = 0;
  int          n_err = 0;

  instr_fetch_unit_if dec_if ();

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (2),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dec_if),
    .misaligned_err (misaligned_err)
  );

  always #5 clk = ~clk;

  // Instruction words: ADD x3,x1,x2 / ADDI x1,x1,1 / SW x2,0(x1), else a pc-derived pattern.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0020_81B3;
      32'h4:   return 32'h0010_8093;
      32'h8:   return 32'h0020_A023;
      default: return ~a;
    endcase
  endfunction

  always @(posedge clk) imem_rdata <= word_of(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst                = r;
    dec_if.instr_ready = rdy;
    redirect_valid     = rv;
    redirect_pc        = rpc;
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'h0, dec_if.instr_valid}, 32'h1);
    chk({tag, "_pc"}, dec_if.pc_out, pc);
    chk({tag, "_instr"}, dec_if.instr_out, word_of(pc));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'h0, dec_if.instr_valid}, 32'h0);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] addr);
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h1);
    chk({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic chk_noreq(input string tag);
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk_noreq(tag);
    chk_empty(tag);
    chk({tag, "_nop"}, dec_if.instr_out, 32'h0000_0013);
    chk({tag, "_pc0"}, dec_if.pc_out, 32'h0);
    chk({tag, "_err"}, {31'h0, misaligned_err}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_if.instr_ready = 1'b1;
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk_reset_outs("rst");

    // fill and latency
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t1c0", 32'h0);  chk_empty("t1c0");
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t1c1", 32'h4);  chk_empty("t1c1");
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t1c2", 32'h8);  chk_head("t1c2", 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t1c3", 32'hC);  chk_head("t1c3", 32'h4);

    // backpressure: FIFO fills to DEPTH and holds
    cyc(1'b0, 1'b0, 1'b0, 32'h0);  chk_noreq("t2c4");  chk_head("t2c4", 32'h8);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      chk_noreq("t2hold");
      chk_head("t2hold", 32'h8);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t2d0", 32'h10);  chk_head("t2d0", 32'h8);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t2d1", 32'h14);  chk_head("t2d1", 32'hC);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t2d2", 32'h18);  chk_head("t2d2", 32'h10);

    // redirect with one entry buffered and one in flight
    cyc(1'b0, 1'b0, 1'b1, 32'h40); chk_noreq("t3r");  chk_head("t3r", 32'h14);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t3a", 32'h40);  chk_empty("t3a");
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t3b", 32'h44);  chk_empty("t3b");
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t3c", 32'h48);  chk_head("t3c", 32'h40);
    cyc(1'b0, 1'b1, 1'b1, 32'h42); chk_noreq("t4r");  chk_head("t4r", 32'h44);

    // misaligned redirect halts fetch
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      chk_noreq("t4err");
      chk_empty("t4err");
      chk("t4err_flag", {31'h0, misaligned_err}, 32'h1);
    end
    cyc(1'b0, 1'b1, 1'b1, 32'h80); chk_noreq("t4fix");
    chk("t4fix_flag", {31'h0, misaligned_err}, 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t4a", 32'h80);
    chk("t4a_flag", {31'h0, misaligned_err}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t4b", 32'h84);  chk_empty("t4b");

    // PC wrap
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8); chk_noreq("t5r");  chk_head("t5r", 32'h80);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t5a", 32'hFFFF_FFF8);  chk_empty("t5a");
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t5b", 32'hFFFF_FFFC);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t5c", 32'h0);  chk_head("t5c", 32'hFFFF_FFF8);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t5d", 32'h4);  chk_head("t5d", 32'hFFFF_FFFC);

    // reset mid-stream
    cyc(1'b1, 1'b1, 1'b0, 32'h0);  chk_reset_outs("t6rst");
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t6a", 32'h0);  chk_empty("t6a");
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_req("t6b", 32'h4);  chk_empty("t6b");
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  chk_head("t6c", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
